// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command sequencer.
// Holds the frame header default, opcodes, ack bytes and parser states.
package uart_cmd_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  localparam logic [7:0] OP_RATE  = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_DATA  = 8'h03;
  localparam logic [7:0] OP_PUSH  = 8'h04;
  localparam logic [7:0] OP_CLEAR = 8'h05;
  localparam logic [7:0] OP_PLAY  = 8'h06;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ARG,
    CSUM,
    EXEC
  } parser_state_t;

endpackage

// File: rtl/uart_cmd_pat_store.sv
// Pattern store: PAT_DEPTH x 8 register file with one write port, one
// combinational read port and length / write / read pointer bookkeeping.
// The read port shows entry 0 while play is asserted, else the read pointer.
module uart_cmd_pat_store #(
  parameter int PAT_DEPTH = 8,
  localparam int AW = $clog2(PAT_DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clear,
  input  logic       play,
  input  logic       step,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  logic [7:0]    mem [PAT_DEPTH];
  logic [AW:0]   len;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // pattern contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // length and pointer bookkeeping; read pointer wraps at len-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      len    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        len    <= len + 1'b1;
      end
      if (play)
        rd_ptr <= (len == (AW+1)'(1)) ? '0 : AW'(1);
      else if (step)
        rd_ptr <= ({1'b0, rd_ptr} == len - 1'b1) ? '0 : rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[play ? '0 : rd_ptr];
  assign full    = (len == (AW+1)'(PAT_DEPTH));
  assign empty   = (len == '0);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Framed UART command parser and pattern playback scheduler.
// Frames are header, opcode, argument, checksum (opcode ^ argument).
// Optional ack/nak generation is enabled by defining UART_CMD_ACK_EN.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int         PAT_DEPTH   = 8,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] HDR_BYTE    = HDR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tick,
  output logic [1:0] rate,
  output logic       start,
  output logic [7:0] data,
  output logic       busy,
  output logic       err,
  output logic       tx_valid,
  output logic [7:0] tx_data
);

  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

  parser_state_t state;
  logic [7:0]    opcode;
  logic [7:0]    arg;
  logic [TW-1:0] tmo_cnt;
  logic          playing;
  logic          in_frame;
  logic          exec;
  logic          tmo_hit;
  logic          csum_bad;
  logic          cmd_err;
  logic          push;
  logic          clear;
  logic          play;
  logic          step;
  logic          full;
  logic          empty;
  logic [7:0]    pat_rd_data;

  assign in_frame = (state == CMD) || (state == ARG) || (state == CSUM);
  assign exec     = (state == EXEC);
  assign tmo_hit  = in_frame && !rx_valid && (tmo_cnt == '0);
  assign csum_bad = (state == CSUM) && rx_valid && (rx_data != (opcode ^ arg));
  assign busy     = (state != IDLE);
  // a tick landing on the EXEC cycle is dropped so the command wins
  assign step     = !exec && playing && start && tick;

  // decode the latched opcode during EXEC into store strobes and errors
  always_comb begin
    cmd_err = 1'b0;
    push    = 1'b0;
    clear   = 1'b0;
    play    = 1'b0;
    if (exec) begin
      case (opcode)
        OP_RATE, OP_START, OP_DATA: begin end
        OP_PUSH:  if (full) cmd_err = 1'b1; else push = 1'b1;
        OP_CLEAR: clear = 1'b1;
        OP_PLAY:  if (empty) cmd_err = 1'b1; else play = 1'b1;
        default:  cmd_err = 1'b1;
      endcase
    end
  end

  // parser FSM with inter-byte timeout and registered command outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      opcode  <= '0;
      arg     <= '0;
      tmo_cnt <= TMO_LOAD;
      rate    <= '0;
      start   <= 1'b0;
      data    <= '0;
      playing <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= tmo_hit || csum_bad || cmd_err;
      if (rx_valid || !in_frame)
        tmo_cnt <= TMO_LOAD;
      else if (tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;
      case (state)
        IDLE: if (rx_valid && rx_data == HDR_BYTE) state <= CMD;
        CMD: begin
          if (rx_valid) begin
            opcode <= rx_data;
            state  <= ARG;
          end else if (tmo_hit) state <= IDLE;
        end
        ARG: begin
          if (rx_valid) begin
            arg   <= rx_data;
            state <= CSUM;
          end else if (tmo_hit) state <= IDLE;
        end
        CSUM: begin
          if (rx_valid) state <= csum_bad ? IDLE : EXEC;
          else if (tmo_hit) state <= IDLE;
        end
        EXEC: begin
          // a byte arriving here is judged as the start of the next frame
          state <= (rx_valid && rx_data == HDR_BYTE) ? CMD : IDLE;
          case (opcode)
            OP_RATE:  rate  <= arg[1:0];
            OP_START: start <= arg[0];
            OP_DATA: begin
              data    <= arg;
              playing <= 1'b0;
            end
            OP_CLEAR: playing <= 1'b0;
            OP_PLAY: begin
              if (play) begin
                data    <= pat_rd_data;
                playing <= 1'b1;
              end
            end
            default: begin end
          endcase
        end
        default: state <= IDLE;
      endcase
      if (step) data <= pat_rd_data;
    end
  end

`ifdef UART_CMD_ACK_EN
  logic frame_end;
  logic frame_nak;

  assign frame_end = tmo_hit || csum_bad || exec;
  assign frame_nak = tmo_hit || csum_bad || cmd_err;

  // one ack/nak byte per completed or rejected frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_valid <= frame_end;
      if (frame_end) tx_data <= frame_nak ? NAK_BYTE : ACK_BYTE;
    end
  end
`else
  assign tx_valid = 1'b0;
  assign tx_data  = '0;
`endif

  uart_cmd_pat_store #(
    .PAT_DEPTH(PAT_DEPTH)
  ) u_pat_store (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(arg),
    .clear    (clear),
    .play     (play),
    .step     (step),
    .rd_data  (pat_rd_data),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer against a queue-based model.
module tb_uart_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int TC    = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tick;
  logic [1:0] rate;
  logic       start;
  logic [7:0] data;
  logic       busy;
  logic       err;
  logic       tx_valid;
  logic [7:0] tx_data;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_rate;
  logic       m_start;
  logic [7:0] m_data;
  logic       m_play;
  logic [7:0] m_pat[$];
  int         m_pos;

  uart_cmd_sequencer #(
    .PAT_DEPTH  (DEPTH),
    .TIMEOUT_CYC(TC),
    .HDR_BYTE   (8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .tick    (tick),
    .rate    (rate),
    .start   (start),
    .data    (data),
    .busy    (busy),
    .err     (err),
    .tx_valid(tx_valid),
    .tx_data (tx_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rate  = '0;
    m_start = 1'b0;
    m_data  = '0;
    m_play  = 1'b0;
    m_pat.delete();
    m_pos   = 0;
  endtask

  task automatic model_exec(input logic [7:0] op, input logic [7:0] a, output bit e);
    e = 1'b0;
    case (op)
      8'h01: m_rate = a[1:0];
      8'h02: m_start = a[0];
      8'h03: begin m_data = a; m_play = 1'b0; end
      8'h04: if (m_pat.size() == DEPTH) e = 1'b1; else m_pat.push_back(a);
      8'h05: begin m_pat.delete(); m_pos = 0; m_play = 1'b0; end
      8'h06: begin
        if (m_pat.size() == 0) e = 1'b1;
        else begin
          m_play = 1'b1;
          m_data = m_pat[0];
          m_pos  = 1 % m_pat.size();
        end
      end
      default: e = 1'b1;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rate"}, 32'(rate), 32'(m_rate));
    check({tag, "_start"}, 32'(start), 32'(m_start));
    check({tag, "_data"}, 32'(data), 32'(m_data));
  endtask

  task automatic check_ack(input string tag, input bit exp_valid, input logic [7:0] exp_byte);
`ifdef UART_CMD_ACK_EN
    check({tag, "_txv"}, 32'(tx_valid), 32'(exp_valid));
    if (exp_valid) check({tag, "_txd"}, 32'(tx_data), 32'(exp_byte));
`else
    check({tag, "_txv"}, 32'(tx_valid), 32'(0));
    check({tag, "_txd"}, 32'(tx_data), 32'(0));
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input bit bad,
                            input int gap, input bit tick_at_exec);
    logic [7:0] cs;
    bit e;
    cs = op ^ a;
    if (bad) cs = cs ^ (8'h01 << $urandom_range(0, 7));
    send_byte(8'hA5);
    repeat (gap) @(negedge clk);
    send_byte(op);
    repeat (gap) @(negedge clk);
    send_byte(a);
    repeat (gap) @(negedge clk);
    send_byte(cs);
    if (bad) begin
      check("csum_err", 32'(err), 32'(1));
      check("csum_busy", 32'(busy), 32'(0));
      check_ack("csum", 1'b1, 8'h15);
      @(negedge clk);
      check("csum_err_clr", 32'(err), 32'(0));
      check_outputs("csum");
    end else begin
      check("exec_busy", 32'(busy), 32'(1));
      check("exec_err", 32'(err), 32'(0));
      if (tick_at_exec) tick = 1'b1;
      model_exec(op, a, e);
      @(negedge clk);
      tick = 1'b0;
      check("cmd_err", 32'(err), 32'(e));
      check("cmd_busy", 32'(busy), 32'(0));
      check_ack("cmd", 1'b1, e ? 8'h15 : 8'h06);
      check_outputs("cmd");
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    if (m_play && m_start) begin
      m_data = m_pat[m_pos];
      m_pos  = (m_pos + 1) % m_pat.size();
    end
    check("tick_data", 32'(data), 32'(m_data));
    check("tick_err", 32'(err), 32'(0));
  endtask

  initial begin
    logic [7:0] junk;
    logic [7:0] rop;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    tick     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    check_outputs("rst");
    check_ack("rst", 1'b0, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // non-header bytes are discarded silently
    for (int i = 0; i < 3; i++) begin
      junk = 8'($urandom_range(0, 255));
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk);
      check("junk_busy", 32'(busy), 32'(0));
      check("junk_err", 32'(err), 32'(0));
      check_ack("junk", 1'b0, 8'h00);
    end

    // RATE 2, then a corrupted checksum leaves rate alone
    send_frame(8'h01, 8'h02, 1'b0, 0, 1'b0);
    check("tp_rate2", 32'(rate), 32'(2));
    send_frame(8'h01, 8'h03, 1'b1, 0, 1'b0);
    check("tp_rate_hold", 32'(rate), 32'(2));

    // push three values, start, play, then step with wrap
    send_frame(8'h04, 8'h11, 1'b0, 0, 1'b0);
    send_frame(8'h04, 8'h22, 1'b0, 1, 1'b0);
    send_frame(8'h04, 8'h33, 1'b0, 2, 1'b0);
    send_frame(8'h02, 8'h01, 1'b0, 0, 1'b0);
    send_frame(8'h06, 8'h00, 1'b0, 0, 1'b0);
    check("tp_play_first", 32'(data), 32'h11);
    repeat (3) do_tick();
    check("tp_wrap", 32'(data), 32'h11);

    // fill the store; the ninth push is rejected
    send_frame(8'h05, 8'h00, 1'b0, 0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++)
      send_frame(8'h04, 8'(8'h40 + i), 1'b0, 0, 1'b0);
    send_frame(8'h06, 8'h00, 1'b0, 0, 1'b0);
    repeat (DEPTH + 2) do_tick();

    // tick coincident with EXEC of DATA 55 is dropped, playback stops
    send_frame(8'h03, 8'h55, 1'b0, 0, 1'b1);
    check("tp_collide", 32'(data), 32'h55);
    repeat (2) do_tick();
    check("tp_after_data", 32'(data), 32'h55);

    // inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TC - 1) @(negedge clk);
    check("tmo_busy_before", 32'(busy), 32'(1));
    check("tmo_err_before", 32'(err), 32'(0));
    @(negedge clk);
    check("tmo_err", 32'(err), 32'(1));
    check("tmo_busy", 32'(busy), 32'(0));
    check_ack("tmo", 1'b1, 8'h15);
    @(negedge clk);
    check("tmo_err_clr", 32'(err), 32'(0));
    send_frame(8'h03, 8'h7F, 1'b0, 0, 1'b0);
    check("tmo_next_data", 32'(data), 32'h7F);

    // randomized frames interleaved with ticks
    for (int i = 0; i < 60; i++) begin
      rop = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) rop = 8'($urandom_range(0, 255));
      send_frame(rop, 8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 3)) do_tick();
    end

    // reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h02);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_err", 32'(err), 32'(0));
    check_outputs("mid_rst");
    check_ack("mid_rst", 1'b0, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    send_frame(8'h06, 8'h00, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
